// File: rtl/vga_text_pkg.sv
// Shared constants for the 80x30 text-mode renderer: glyph geometry, address
// widths, pipeline latency and the 16-entry CGA palette.
package vga_text_pkg;

  localparam int CHAR_W      = 8;
  localparam int CHAR_H      = 16;
  localparam int TEXT_ADDR_W = 12;
  localparam int FONT_ADDR_W = 12;
  localparam int PIPE_LAT    = 5;

  localparam logic [11:0] CGA_PALETTE [16] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  function automatic logic [11:0] palette_lookup(input logic [3:0] idx);
    return CGA_PALETTE[idx];
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register carrying side-channel data (syncs, de, fine
// coordinates, attribute) alongside the RAM/ROM fetch pipeline.
module vga_delay_line #(
  parameter int              WIDTH     = 1,
  parameter int              DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift chain; stage 0 captures the input
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= RESET_VAL;
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_text_renderer.sv
// Text-mode pixel pipeline: text RAM -> font ROM -> palette -> DAC, with syncs
// delayed to match. Optional underline cursor enabled by VGA_TEXT_CURSOR_EN.
module vga_text_renderer
  import vga_text_pkg::*;
#(
  parameter int   TEXT_COLS    = 80,
  parameter int   TEXT_ROWS    = 30,
  parameter logic SYNC_POL     = 1'b0,
  parameter int   BLINK_FRAMES = 32
) (
  input  logic                   pixel_clk,
  input  logic                   rst_n,
  input  logic [31:0]            x,
  input  logic [31:0]            y,
  input  logic                   disp_en,
  input  logic                   h_sync_in,
  input  logic                   v_sync_in,
  output logic [TEXT_ADDR_W-1:0] text_addr,
  input  logic [15:0]            text_data,
  output logic [FONT_ADDR_W-1:0] font_addr,
  input  logic [7:0]             font_data,
  input  logic [6:0]             cursor_col,
  input  logic [4:0]             cursor_row,
  output logic [3:0]             r,
  output logic [3:0]             g,
  output logic [3:0]             b,
  output logic                   h_sync,
  output logic                   v_sync
);

  localparam int              CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [6:0]  col_s;
  logic [4:0]  row_s;
  logic [2:0]  fine_x_s;
  logic [3:0]  fine_y_s;
  logic [31:0] addr_full_s;
  logic        de_d5_s;
  logic [1:0]  sync_d5_s;
  logic [2:0]  fine_x_d4_s;
  logic [3:0]  fine_y_d2_s;
  logic [7:0]  attr_d4_s;
  logic [11:0] fg_s;
  logic [11:0] bg_s;
  logic [11:0] fg_sel_s;
  logic [11:0] color_s;
  logic [11:0] color_r;
  logic        pixel_on_s;
  logic        vs_prev_r;
  logic        frame_evt_s;
  logic [CNT_W-1:0] frame_cnt_r;
  logic        blink_phase_r;
  logic        unused_s;

  assign col_s       = x[9:3];
  assign row_s       = y[8:4];
  assign fine_x_s    = x[2:0];
  assign fine_y_s    = y[3:0];
  assign addr_full_s = 32'(row_s) * 32'(TEXT_COLS) + 32'(col_s);

  // E0: text RAM address, wraps modulo 4096 for oversized parameter sets
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) text_addr <= '0;
    else        text_addr <= addr_full_s[TEXT_ADDR_W-1:0];
  end

  vga_delay_line #(.WIDTH(1), .DEPTH(5), .RESET_VAL(1'b0)) u_de_dly (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .d(disp_en), .q(de_d5_s));

  vga_delay_line #(.WIDTH(2), .DEPTH(5), .RESET_VAL({~SYNC_POL, ~SYNC_POL})) u_sync_dly (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .d({h_sync_in, v_sync_in}), .q(sync_d5_s));

  vga_delay_line #(.WIDTH(3), .DEPTH(4), .RESET_VAL(3'd0)) u_fx_dly (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .d(fine_x_s), .q(fine_x_d4_s));

  vga_delay_line #(.WIDTH(4), .DEPTH(2), .RESET_VAL(4'd0)) u_fy_dly (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .d(fine_y_s), .q(fine_y_d2_s));

  // Attribute is captured from the RAM at E2 and held one more stage for E4
  vga_delay_line #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'd0)) u_attr_dly (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .d(text_data[15:8]), .q(attr_d4_s));

  // E2: font ROM address from the fetched character and its glyph row
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) font_addr <= '0;
    else        font_addr <= {text_data[7:0], fine_y_d2_s};
  end

  assign frame_evt_s = (v_sync_in == SYNC_POL) && (vs_prev_r != SYNC_POL);

  // One count per vertical sync assertion; blink phase flips on wrap
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_r     <= ~SYNC_POL;
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else begin
      vs_prev_r <= v_sync_in;
      if (frame_evt_s) begin
        if (frame_cnt_r == CNT_LAST) begin
          frame_cnt_r   <= '0;
          blink_phase_r <= ~blink_phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + 1'b1;
        end
      end
    end
  end

`ifdef VGA_TEXT_CURSOR_EN
  logic cursor_hit_s;
  logic cursor_d4_s;

  assign cursor_hit_s = (col_s == cursor_col) && (row_s == cursor_row) &&
                        (fine_y_s[3:1] == 3'b111);

  vga_delay_line #(.WIDTH(1), .DEPTH(4), .RESET_VAL(1'b0)) u_cur_dly (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .d(cursor_hit_s), .q(cursor_d4_s));

  assign unused_s = ^{x[31:10], y[31:9], 1'(TEXT_ROWS)};
`else
  assign unused_s = ^{x[31:10], y[31:9], 1'(TEXT_ROWS), cursor_col, cursor_row};
`endif

  assign fg_s = palette_lookup(attr_d4_s[3:0]);
  assign bg_s = palette_lookup({1'b0, attr_d4_s[6:4]});

  // E4: glyph bit select, blink masking and cursor override
  always_comb begin
    fg_sel_s   = fg_s;
    pixel_on_s = font_data[3'd7 - fine_x_d4_s];
    color_s    = bg_s;
    if (attr_d4_s[7] && blink_phase_r) fg_sel_s = bg_s;
    else                               fg_sel_s = fg_s;
`ifdef VGA_TEXT_CURSOR_EN
    if (cursor_d4_s && !blink_phase_r) pixel_on_s = 1'b1;
    else                               pixel_on_s = font_data[3'd7 - fine_x_d4_s];
`endif
    if (pixel_on_s) color_s = fg_sel_s;
    else            color_s = bg_s;
  end

  // E4 colour register, E5 blanked DAC outputs and aligned syncs
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      color_r <= 12'h000;
      r       <= 4'h0;
      g       <= 4'h0;
      b       <= 4'h0;
      h_sync  <= ~SYNC_POL;
      v_sync  <= ~SYNC_POL;
    end else begin
      color_r <= color_s;
      if (de_d5_s) {r, g, b} <= color_r;
      else         {r, g, b} <= 12'h000;
      h_sync <= sync_d5_s[1];
      v_sync <= sync_d5_s[0];
    end
  end

endmodule

// File: doc/vga_text_renderer.md
Name: vga_text_renderer

Overview:
- Downstream stage of the VGA timing controller. Consumes its registered x/y/disp_en/h_sync/v_sync and produces per-pixel RGB for an 80x30 text mode with 8x16 glyphs.
- Fetches the character/attribute word from an external synchronous text RAM, then the glyph row from an external synchronous font ROM. Maps colours through a 16-entry palette.
- Delays the syncs so RGB and syncs leave aligned to the DAC pins.

Parameters:
TEXT_COLS, 80, characters per row
TEXT_ROWS, 30, character rows
SYNC_POL, 1'b0, active level of incoming/outgoing syncs
BLINK_FRAMES, 32, frames per blink half-period (>=1)

Ports:
pixel_clk  in  1  pixel clock
rst_n  in  1  reset, asynchronous assert, active-low
x  in  32  pixel column from timing controller
y  in  32  pixel row from timing controller
disp_en  in  1  active-video flag
h_sync_in  in  1  horizontal sync
v_sync_in  in  1  vertical sync
text_addr  out  12  text RAM address (row*TEXT_COLS+col)
text_data  in  16  {attr[7:0], char[7:0]}, valid 1 cycle after address
font_addr  out  12  font ROM address {char[7:0], glyph_row[3:0]}
font_data  in  8  glyph row, bit 7 = leftmost pixel, valid 1 cycle after address
cursor_col  in  7  cursor column (used only with CURSOR_EN)
cursor_row  in  5  cursor row (used only with CURSOR_EN)
r, g, b  out  4 each  colour to DAC
h_sync  out  1  delayed sync
v_sync  out  1  delayed sync

Behaviour:
- Interface fixed: single clock pixel_clk; rst_n asynchronous, active-low.
- Reset values: text_addr=0, font_addr=0, r=g=b=0, h_sync=v_sync=!SYNC_POL, all pipeline and delay regs clear (de=0, syncs inactive), frame counter=0, blink phase=0.
- Reset mid-frame: outputs hold their reset values while rst_n is low. The first valid pixel emerges 5 edges after release. No recovery handshake is needed because upstream keeps scanning.
- Pipeline: inputs sampled at edge N appear on r/g/b/h_sync/v_sync after edge N+5.
  - E0: col=x[9:3], row=y[8:4], fine_x=x[2:0], fine_y=y[3:0]; text_addr<=row*TEXT_COLS+col, truncated to 12 bits. 2399 max, no overflow at default parameters.
  - E1: RAM presents text_data.
  - E2: font_addr<={char, fine_y_d2}; latch attr.
  - E3: ROM presents font_data.
  - E4: pixel_on<=font_data[7-fine_x_d4]; choose colour.
  - E5: r/g/b, h_sync, v_sync registered out.
- de, fine_x, fine_y, attr, h_sync, v_sync travel through delay registers of matching depth.
- Colour: fg=palette[attr[3:0]], bg=palette[{1'b0,attr[6:4]}]. Palette is the 12-bit CGA 16 colours.
  - attr[7]=1 and blink phase=1: fg replaced by bg (text hidden).
- Blanking: delayed de=0 forces r=g=b=0 regardless of RAM/ROM contents.
- Frame counter: detects the v_sync_in transition to SYNC_POL (edge-detect register).
  - Counts 0..BLINK_FRAMES-1, then wraps to 0 and toggles blink phase.
  - Exactly one increment per frame; a sync held active for multiple lines counts once.
- Upstream x/y may hold their last value during blanking. Addresses then repeat but output stays blanked, so this is harmless.
- Rows beyond TEXT_ROWS cannot occur with 480 lines. With other parameter sets, addresses wrap modulo 4096.

Optional Feature:
- VGA_TEXT_CURSOR_EN defined:
  - When the delayed cell equals {cursor_col, cursor_row}, fine_y in 14..15, and blink phase=0, the pixel is forced to fg (underline cursor).
  - cursor_col/cursor_row are sampled at E0 and compared against col/row there; the result travels down the pipe.
- Undefined: cursor ports are ignored and no comparator logic is present.

Decomposition:
- Package vga_text_pkg:
  - CHAR_W=8, CHAR_H=16, TEXT_ADDR_W=12, FONT_ADDR_W=12.
  - 16x12-bit CGA palette constant.
  - Pipeline depth constant PIPE_LAT=5.
- Sub-module vga_delay_line (parameters WIDTH, DEPTH, RESET_VAL; async active-low reset). Used for the sync/de/fine-coordinate/attr side channels.

Test Plan:
- Reset release mid-line, then disp_en=0 for 5 cycles -> r=g=b=0 and h_sync=v_sync=1 throughout; first active pixel appears exactly 5 edges after its inputs.
- x=17, y=35, disp_en=1 -> text_addr=2*80+2=162 one edge later. With text_data=16'h1F41 -> font_addr={8'h41,4'h3}=12'h413 at E2.
- font_data=8'b1000_0001, attr=8'h1F, x=8..15 on the same row -> pixels 8 and 15 white (FFF), pixels 9..14 blue (00A).
- disp_en dropped while font_data=8'hFF -> rgb=000 on the matching output cycle; sync edges delayed exactly 5 cycles.
- attr=8'h8F, BLINK_FRAMES=2, 4 v_sync pulses -> glyph visible in frames 0-1, hidden in frames 2-3, visible in frame 4.
- With VGA_TEXT_CURSOR_EN, cursor=(5,3), blink phase 0 -> y=62..63, x=40..47 all fg. Same region in phase 1 shows glyph/bg only.
